cw305_usb_regbank: RTL and testbench
====================================

CW305_USB_REGBANK -- requirements
Module: cw305_usb_regbank

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 8, meaning log2 of bytes per memory region.
REQ-002 SHALL have parameter ADDR_WIDTH, default 21, meaning host address bus width.
REQ-003 SHALL have parameter RDDLY_LEN, default 3, meaning clk_usb cycles the bus stays driven after rd_n deasserts.
REQ-004 SHALL have port clk_usb, input, 1 bit: the one clock, rising-edge; all sequential logic is on clk_usb.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data, inout, 8 bits: host data bus.
REQ-007 SHALL have port addr, input, ADDR_WIDTH bits: host address.
REQ-008 SHALL have port rd_n, input, 1 bit: active-low read strobe, asynchronous to clk_usb.
REQ-009 SHALL have port wr_n, input, 1 bit: active-low write strobe, asynchronous to clk_usb.
REQ-010 SHALL have port memory_input, output, 2^MEMORY_WIDTH*8 bits: host-written bytes to the core.
REQ-011 SHALL have port memory_output, input, 2^MEMORY_WIDTH*8 bits: core result bytes to the host.
REQ-012 SHALL have port go, output, 1 bit: one-cycle start pulse to the core.
REQ-013 SHALL have port busy, input, 1 bit: core busy level.
REQ-014 SHALL have port done, input, 1 bit: core completion pulse.

Function
REQ-015 SHALL decode regions with N = 2^MEMORY_WIDTH: OUT = [0, N-1], read-only; IN = [N, 2N-1], read/write; CTRL = 2N; STATUS = 2N+1; any other address is unmapped.
REQ-016 SHALL synchronise rd_n and wr_n through two flops each (rd_s, wr_s); the strobes are never used as clocks.
REQ-017 SHALL register addr and data into addr_q and data_q on every cycle in which wr_s = 0.
REQ-018 SHALL commit a write in the cycle after wr_s goes 0->1, using addr_q and data_q; commit is 3 clk_usb cycles after the wr_n pin rises.
REQ-019 SHALL, on an IN-region commit, write byte (addr_q - N) of memory_input.
REQ-020 SHALL, on a CTRL commit with data_q[0] = 1 and busy = 0, pulse go high for exactly one cycle.
REQ-021 SHALL, on a CTRL commit with data_q[0] = 1 and busy = 1, suppress go and set sticky err.
REQ-022 SHALL ignore OUT-region, STATUS and unmapped writes.
REQ-023 SHALL latch data_out one cycle after rd_s goes 1->0: OUT region returns memory_output byte addr; STATUS returns {5'b0, err, done_flag, busy}; CTRL returns 0x00; unmapped returns 0x00.
REQ-024 SHALL implement a hold counter that loads RDDLY_LEN while rd_s = 0 and decrements to 0 otherwise.
REQ-025 SHALL drive data = data_out when (rd_n pin = 0 or hold counter != 0) and wr_s = 1, and tri-state data otherwise.
REQ-026 SHALL give writes precedence when rd_s and wr_s are both 0: bus tri-stated, no data_out update, write still commits.
REQ-027 SHALL set sticky done_flag on done = 1.
REQ-028 SHALL clear done_flag and err on the rd_s falling edge of a STATUS read; a done arriving in that same cycle leaves done_flag set.

Reset
REQ-029 SHALL, while rst_n = 0, immediately set: memory_input = 0, go = 0, done_flag = 0, err = 0, data_out = 0x00, hold counter = 0, synchroniser flops = 1, addr_q = 0, data_q = 0, data tri-stated.
REQ-030 SHALL abandon any strobe in progress when rst_n asserts, with no partial commit; a wr_n still low at deassertion commits normally when it rises.

Configuration
REQ-031 SHALL, with macro CW305_USB_READBACK_EN defined, return byte (addr - N) of memory_input on IN-region reads.
REQ-032 SHALL, without CW305_USB_READBACK_EN, return 0x00 on IN-region reads and synthesise no readback mux.

Verification
REQ-033 SHALL cover: write 0xA5 to addr N+3 -> memory_input[31:24] = 0xA5 three cycles after the wr_n pin rises; all other bytes unchanged.
REQ-034 SHALL cover: memory_output byte 7 = 0x3C, read addr 7 -> data = 0x3C while rd_n is low and for 3 cycles after its rise, then Z.
REQ-035 SHALL cover: busy = 0, write 0x01 to 2N -> go high exactly one cycle; repeat with busy = 1 -> no go, STATUS read = 0x05.
REQ-036 SHALL cover: done pulse, then STATUS read = 0x02; second STATUS read = 0x00.
REQ-037 SHALL cover: readback macro on, write 0x5A to N, read N -> 0x5A; macro off, same read -> 0x00.
REQ-038 SHALL cover: rst_n asserted mid-write (wr_n low) -> memory_input unchanged at 0, go = 0, bus Z.

Source files
------------

// File: rtl/cw305_usb_regbank.sv
// Host-bus register bank: async rd_n/wr_n strobes, IN/OUT byte windows,
// CTRL go pulse, STATUS flags. Optional IN readback: CW305_USB_READBACK_EN.
//
// Ports:
//   clk_usb       - the only clock, rising edge
//   rst_n         - asynchronous active-low reset
//   data          - 8-bit bidirectional host data bus
//   addr          - host address, ADDR_WIDTH bits
//   rd_n, wr_n    - active-low host strobes, asynchronous to clk_usb
//   memory_input  - host-written IN bytes toward the core
//   memory_output - core result bytes readable in the OUT window
//   go            - one-cycle start pulse to the core
//   busy, done    - core busy level and completion pulse
//
// Address map, N = 2**MEMORY_WIDTH:
//   OUT [0, N-1] read-only, IN [N, 2N-1] read/write,
//   CTRL 2N, STATUS 2N+1, everything else unmapped.
module cw305_usb_regbank #(
  parameter int MEMORY_WIDTH = 8,
  parameter int ADDR_WIDTH   = 21,
  parameter int RDDLY_LEN    = 3
) (
  input  logic                           clk_usb,
  input  logic                           rst_n,
  inout  wire  [7:0]                     data,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           rd_n,
  input  logic                           wr_n,
  output logic [(2**MEMORY_WIDTH)*8-1:0] memory_input,
  input  logic [(2**MEMORY_WIDTH)*8-1:0] memory_output,
  output logic                           go,
  input  logic                           busy,
  input  logic                           done
);

  localparam int N  = 2 ** MEMORY_WIDTH;
  localparam int MW = N * 8;
  localparam int HW = (RDDLY_LEN > 0) ? $clog2(RDDLY_LEN + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] A_IN   = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(2 * N);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(2 * N + 1);

  // Strobe synchronisers plus one delay stage for edge detection
  logic rd_meta_q, rd_s_q, rd_d_q;
  logic wr_meta_q, wr_s_q, wr_d_q;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;

  logic [MW-1:0] mem_q, mem_d;
  logic          go_q, go_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [7:0]    dout_q, dout_d;
  logic [HW-1:0] hold_q, hold_d;

  logic                    commit;
  logic                    rd_fall;
  logic                    stat_clr;
  logic                    w_in, w_ctrl;
  logic                    r_out, r_stat;
  logic [MEMORY_WIDTH-1:0] widx, ridx;
  logic [7:0]              rdata;
  logic                    drive;

  always_comb begin
    // N is aligned, so the low address bits index both windows directly
    widx   = addr_q[MEMORY_WIDTH-1:0];
    ridx   = addr[MEMORY_WIDTH-1:0];
    w_in   = (addr_q >= A_IN) && (addr_q < A_CTRL);
    w_ctrl = (addr_q == A_CTRL);
    r_out  = (addr < A_IN);
    r_stat = (addr == A_STAT);

    commit   = wr_s_q & ~wr_d_q;
    // A read that overlaps an active write is dropped entirely
    rd_fall  = ~rd_s_q & rd_d_q & wr_s_q;
    stat_clr = rd_fall & r_stat;
  end

  always_comb begin
    rdata = 8'h00;
    if (r_out) begin
      rdata = memory_output[{ridx, 3'b000} +: 8];
    end else if (r_stat) begin
      rdata = {5'b0, err_q, done_q, busy};
    end
`ifdef CW305_USB_READBACK_EN
    else if ((addr >= A_IN) && (addr < A_CTRL)) begin
      rdata = mem_q[{ridx, 3'b000} +: 8];
    end
`endif
  end

  always_comb begin
    mem_d = mem_q;
    if (commit && w_in) begin
      mem_d[{widx, 3'b000} +: 8] = data_q;
    end

    go_d = commit & w_ctrl & data_q[0] & ~busy;

    err_d = err_q;
    if (stat_clr) err_d = 1'b0;
    if (commit && w_ctrl && data_q[0] && busy) err_d = 1'b1;

    // A done in the clearing cycle wins
    done_d = done_q;
    if (stat_clr) done_d = 1'b0;
    if (done) done_d = 1'b1;

    dout_d = rd_fall ? rdata : dout_q;

    hold_d = hold_q;
    if (!rd_s_q) begin
      hold_d = HW'(RDDLY_LEN);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk_usb or negedge rst_n) begin
    if (!rst_n) begin
      rd_meta_q <= 1'b1;
      rd_s_q    <= 1'b1;
      rd_d_q    <= 1'b1;
      wr_meta_q <= 1'b1;
      wr_s_q    <= 1'b1;
      wr_d_q    <= 1'b1;
      addr_q    <= '0;
      data_q    <= 8'h00;
      mem_q     <= '0;
      go_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= 8'h00;
      hold_q    <= '0;
    end else begin
      rd_meta_q <= rd_n;
      rd_s_q    <= rd_meta_q;
      rd_d_q    <= rd_s_q;
      wr_meta_q <= wr_n;
      wr_s_q    <= wr_meta_q;
      wr_d_q    <= wr_s_q;
      if (!wr_s_q) begin
        addr_q <= addr;
        data_q <= data;
      end
      mem_q  <= mem_d;
      go_q   <= go_d;
      err_q  <= err_d;
      done_q <= done_d;
      dout_q <= dout_d;
      hold_q <= hold_d;
    end
  end

  // The raw rd_n pin opens the bus at once; the hold counter keeps
  // it driven briefly after rd_n rises. A pending write closes it.
  assign drive = (~rd_n | (hold_q != '0)) & wr_s_q;
  assign data  = drive ? dout_q : 8'hzz;

  assign memory_input = mem_q;
  assign go           = go_q;

endmodule

// File: tb/tb_cw305_usb_regbank.sv
// Self-checking bench for cw305_usb_regbank: vector table plus
// hand-written sequences for reset, timing, go and status flags.
module tb_cw305_usb_regbank;

  localparam int AW = 21;
  localparam int N  = 256;
  localparam int W  = N * 8;

`ifdef CW305_USB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          rd_n, wr_n, busy, done;
  logic [W-1:0]  mout;
  wire  [W-1:0]  min;
  wire           go;
  tri1  [7:0]    data;
  logic          tb_en;
  logic [7:0]    tb_val;

  assign data = tb_en ? tb_val : 8'hzz;

  always #5 clk = ~clk;

  cw305_usb_regbank dut (
    .clk_usb       (clk),
    .rst_n         (rst_n),
    .data          (data),
    .addr          (addr),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .memory_input  (min),
    .memory_output (mout),
    .go            (go),
    .busy          (busy),
    .done          (done)
  );

  int total = 0;
  int bad   = 0;
  int go_cnt = 0;

  logic [W-1:0] model;
  logic [W-1:0] sb_mem[$];
  logic [7:0]   sb_rd[$];

  always @(posedge clk) begin
    #1;
    if (go === 1'b1) go_cnt++;
  end

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    exp;
    string         nm;
  } vec_t;

  vec_t v[11];

  task automatic check8(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic check_int(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_mem(string nm, logic [W-1:0] exp);
    total++;
    if (min !== exp) begin
      bad++;
      for (int i = 0; i < N; i++) begin
        if (min[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL %s: byte %0d got %02h want %02h",
                   nm, i, min[i*8 +: 8], exp[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  function automatic void model_wr(logic [AW-1:0] a, logic [7:0] d);
    if (a >= AW'(N) && a < AW'(2 * N)) begin
      model[(int'(a) - N) * 8 +: 8] = d;
    end
  endfunction

  task automatic do_write(logic [AW-1:0] a, logic [7:0] d);
    @(negedge clk);
    addr   = a;
    tb_val = d;
    tb_en  = 1'b1;
    wr_n   = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (4) @(negedge clk);
    tb_en = 1'b0;
  endtask

  task automatic do_read(logic [AW-1:0] a, output logic [7:0] r);
    @(negedge clk);
    addr = a;
    rd_n = 1'b0;
    repeat (4) @(negedge clk);
    r    = data;
    rd_n = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic sb_write(string nm, logic [AW-1:0] a, logic [7:0] d);
    model_wr(a, d);
    sb_mem.push_back(model);
    do_write(a, d);
    check_mem(nm, sb_mem.pop_front());
  endtask

  task automatic sb_read(string nm, logic [AW-1:0] a, logic [7:0] e);
    logic [7:0] r;
    sb_rd.push_back(e);
    do_read(a, r);
    check8(nm, r, sb_rd.pop_front());
  endtask

  initial begin
    logic [W-1:0] prev;
    int g0;

    v[0]  = '{1'b0, AW'(N),         8'h11, 8'h00, "wr_in_lo"};
    v[1]  = '{1'b0, AW'(N + 255),   8'hEE, 8'h00, "wr_in_hi"};
    v[2]  = '{1'b0, AW'(5),         8'h99, 8'h00, "wr_out_ign"};
    v[3]  = '{1'b0, AW'(2 * N + 1), 8'h77, 8'h00, "wr_stat_ign"};
    v[4]  = '{1'b0, AW'(600),       8'h55, 8'h00, "wr_unmap_ign"};
    v[5]  = '{1'b1, AW'(0),         8'h00, 8'h5A, "rd_out_lo"};
    v[6]  = '{1'b1, AW'(255),       8'h00, 8'hA5, "rd_out_hi"};
    v[7]  = '{1'b1, AW'(2 * N),     8'h00, 8'h00, "rd_ctrl"};
    v[8]  = '{1'b1, AW'(600),       8'h00, 8'h00, "rd_unmap"};
    v[9]  = '{1'b1, AW'(N + 255),   8'h00,
              (RB ? 8'hEE : 8'h00), "rd_in_hi"};
    v[10] = '{1'b1, AW'(2 * N + 1), 8'h00, 8'h00, "rd_stat_idle"};

    for (int i = 0; i < N; i++) mout[i*8 +: 8] = 8'(i) ^ 8'h5A;
    mout[7*8 +: 8] = 8'h3C;
    model  = '0;
    rst_n  = 1'b0;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    busy   = 1'b0;
    done   = 1'b0;
    addr   = '0;
    tb_en  = 1'b0;
    tb_val = 8'h00;

    repeat (2) @(negedge clk);
    check_mem("rst_mem", '0);
    check8("rst_go", {7'b0, go}, 8'h00);
    check8("rst_bus_z", data, 8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset asserted in the middle of a write
    addr   = AW'(N);
    tb_val = 8'h77;
    tb_en  = 1'b1;
    wr_n   = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_mem("midrst_mem", '0);
    check8("midrst_go", {7'b0, go}, 8'h00);
    tb_en = 1'b0;
    wr_n  = 1'b1;
    #1;
    check8("midrst_bus_z", data, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_mem("midrst_no_commit", '0);

    // commit latency: three clocks after wr_n rises
    prev = model;
    model_wr(AW'(N + 3), 8'hA5);
    sb_mem.push_back(model);
    @(negedge clk);
    addr   = AW'(N + 3);
    tb_val = 8'hA5;
    tb_en  = 1'b1;
    wr_n   = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (2) @(negedge clk);
    check_mem("wr_n3_early", prev);
    @(negedge clk);
    check8("wr_n3_byte", min[31:24], 8'hA5);
    check_mem("wr_n3_all", sb_mem.pop_front());
    repeat (2) @(negedge clk);
    tb_en = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (v[i].rd) sb_read(v[i].nm, v[i].a, v[i].exp);
      else         sb_write(v[i].nm, v[i].a, v[i].d);
    end

    // OUT read: bus held for the hold window, then released
    @(negedge clk);
    addr = AW'(7);
    rd_n = 1'b0;
    repeat (4) @(negedge clk);
    check8("rd7_low", data, 8'h3C);
    rd_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check8($sformatf("rd7_hold%0d", i), data, 8'h3C);
    end
    repeat (3) @(negedge clk);
    check8("rd7_release", data, 8'hFF);

    // go pulses
    busy = 1'b0;
    g0 = go_cnt;
    do_write(AW'(2 * N), 8'h01);
    check_int("go_one_cycle", go_cnt - g0, 1);
    g0 = go_cnt;
    do_write(AW'(2 * N), 8'h00);
    check_int("go_bit0_clear", go_cnt - g0, 0);
    busy = 1'b1;
    g0 = go_cnt;
    do_write(AW'(2 * N), 8'h01);
    check_int("go_busy_blocked", go_cnt - g0, 0);
    sb_read("stat_err_busy", AW'(2 * N + 1), 8'h05);
    busy = 1'b0;

    // done flag is sticky until a STATUS read
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    sb_read("stat_done", AW'(2 * N + 1), 8'h02);
    sb_read("stat_cleared", AW'(2 * N + 1), 8'h00);

    // IN readback
    sb_write("wr_rb", AW'(N), 8'h5A);
    sb_read("rd_rb", AW'(N), RB ? 8'h5A : 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
